// File: rtl/robo_pkg.sv
// Shared types and constants for the robot execution controller.
// Holds the FSM state enum, debris classes and removal duration helper.
package robo_pkg;

  typedef enum logic [1:0] {
    SRST   = 2'd0,
    RUN    = 2'd1,
    REMOVE = 2'd2,
    HALT   = 2'd3
  } state_e;

  localparam logic [1:0] NONE   = 2'd0;
  localparam logic [1:0] LEVE   = 2'd1;
  localparam logic [1:0] MEDIO  = 2'd2;
  localparam logic [1:0] PESADO = 2'd3;

  localparam logic [3:0] REMOVE_MULT = 4'd3;

  function automatic logic [3:0] removal_ticks(
    input logic [1:0] tipo
  );
    return 4'(tipo) * REMOVE_MULT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rise pulse.
// Ports: clock, reset (async low), btn (raw), pulse (one cycle per press).
module btn_debounce
  import robo_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level is adopted only after an unbroken
  // run of differing samples; any agreeing sample
  // restarts the run.
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CMAX) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/robo_exec_ctrl.sv
// Robot execution controller: tick source, removal stall, halt latch.
// Ports: buttons, removal request/class, anomaly in; enables/status out.
module robo_exec_ctrl
  import robo_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_reset,
  input  logic       btn_mode,
  input  logic       btn_step,
  input  logic       recolher_entulho,
  input  logic [1:0] entulho_tipo,
  input  logic       anomalia,
  output logic       robo_en,
  output logic       robo_rst_n,
  output logic       step_mode,
  output logic       removendo,
  output logic [3:0] entulho_restante,
  output logic       entulho_limpo,
  output logic       halted
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(TICK_DIV - 1);

  logic p_reset, p_mode, p_step;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reset (
    .clock (clock),
    .reset (reset),
    .btn   (btn_reset),
    .pulse (p_reset)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clock (clock),
    .reset (reset),
    .btn   (btn_mode),
    .pulse (p_mode)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clock (clock),
    .reset (reset),
    .btn   (btn_step),
    .pulse (p_step)
  );

  state_e          state_q, state_d;
  logic            srst_q, srst_d;
  logic [DW-1:0]   div_q, div_d;
  logic            mode_q, mode_d;
  logic [3:0]      rest_q, rest_d;
  logic            en_q, en_d;
  logic            limpo_q, limpo_d;
  logic            wrap, tick, start_rm;

  always_comb begin
    state_d  = state_q;
    srst_d   = srst_q;
    mode_d   = mode_q ^ p_mode;
    rest_d   = rest_q;
    en_d     = 1'b0;
    limpo_d  = 1'b0;
    wrap     = (div_q == DMAX);
    div_d    = (p_mode || wrap) ? '0 : div_q + DW'(1);
    // A mode toggle swallows any tick of that cycle.
    tick     = !p_mode && (mode_q ? p_step : wrap);
    start_rm = recolher_entulho && (entulho_tipo != NONE);
    if (p_reset) begin
      state_d = SRST;
      srst_d  = 1'b0;
      div_d   = '0;
      rest_d  = '0;
    end else begin
      unique case (state_q)
        SRST: begin
          div_d  = '0;
          rest_d = '0;
          srst_d = 1'b1;
          if (srst_q) state_d = RUN;
        end
        RUN: begin
          if (anomalia) begin
            state_d = HALT;
          end else if (tick) begin
            if (start_rm) begin
              rest_d  = removal_ticks(entulho_tipo);
              state_d = REMOVE;
            end else begin
              en_d = 1'b1;
            end
          end
        end
        REMOVE: begin
          if (anomalia) begin
            state_d = HALT;
            rest_d  = '0;
          end else if (tick) begin
            rest_d = rest_q - 4'd1;
            if (rest_q == 4'd1) begin
              limpo_d = 1'b1;
              state_d = RUN;
            end
          end
        end
        HALT: ;
        default: state_d = SRST;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SRST;
      srst_q  <= 1'b0;
      div_q   <= '0;
      mode_q  <= 1'b0;
      rest_q  <= '0;
      en_q    <= 1'b0;
      limpo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      srst_q  <= srst_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      rest_q  <= rest_d;
      en_q    <= en_d;
      limpo_q <= limpo_d;
    end
  end

  assign robo_en          = en_q;
  assign entulho_limpo    = limpo_q;
  assign step_mode        = mode_q;
  assign entulho_restante = rest_q;
  assign robo_rst_n       = (state_q != SRST);
  assign removendo        = (state_q == REMOVE);
  assign halted           = (state_q == HALT);

endmodule

// File: doc/robo_exec_ctrl.md
# robo_exec_ctrl

Execution controller that sequences the robot FSM (`Robo`) in hardware. It debounces the three operator buttons and generates the robot's advance enable, either continuously or one step per button press. It also stalls the robot for the debris-removal duration and latches a halt on anomaly until the operator resets. It sits between the board buttons / map-sensing logic and the `Robo` instance.

## Interface
- `TICK_DIV`, default 4: clock cycles between enables in continuous mode (≥2).
- `DEB_CYCLES`, default 4: cycles a synchronized button must stay stable before it is accepted (≥1).

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `btn_reset`, `btn_mode`, `btn_step` in 1 each: raw, asynchronous, active-high buttons.
- `recolher_entulho` in 1: removal request from the robot.
- `entulho_tipo` in 2: debris class ahead of the robot. 0 = none, 1 = light, 2 = medium, 3 = heavy.
- `anomalia` in 1: robot off-map or inside a wall.
- `robo_en` out 1: one-cycle pulse; the robot advances one state on it.
- `robo_rst_n` out 1: soft reset to the robot, active-low.
- `step_mode` out 1: 0 = continuous, 1 = step-by-step.
- `removendo` out 1: high while a removal is in progress.
- `entulho_restante` out 4: removal ticks remaining.
- `entulho_limpo` out 1: one-cycle pulse when a removal completes; the map cell is cleared on it.
- `halted` out 1: high while the controller is latched in halt.

## Operation
- Buttons pass through a 2-flop synchronizer, then a stability counter, then a rising-edge detector. Output is a one-cycle internal pulse per accepted press (`p_reset`, `p_mode`, `p_step`).
- Tick source:
  - Continuous mode: divider counts 0..TICK_DIV-1; `tick` is high when the count equals TICK_DIV-1.
  - Step mode: `tick` = `p_step`.
- `p_mode` toggles `step_mode` in any state and clears the divider to 0.
- States:
  - SRST: `robo_rst_n`=0 for exactly 2 cycles, then go to RUN. Divider and `entulho_restante` are held at 0.
  - RUN, on `tick`:
    - If `recolher_entulho`=1 and `entulho_tipo`≠0: suppress `robo_en`, load `entulho_restante` = 3·`entulho_tipo` (3/6/9), go to REMOVE.
    - Otherwise: pulse `robo_en`.
  - REMOVE: `removendo`=1. Each `tick` decrements `entulho_restante`. On the tick that takes it 1→0: pulse `entulho_limpo`, return to RUN. No `robo_en` is issued on that tick.
  - HALT: `halted`=1; no ticks take effect. Only `p_reset` exits.
- Priority within a cycle: `p_reset` (→SRST from any state) > `anomalia` (→HALT from RUN/REMOVE; ignored in SRST) > removal start/decrement > `robo_en`.
- `p_mode` and `p_step` in the same cycle: the toggle applies and the step is discarded.
- An anomaly during REMOVE aborts the removal: `entulho_restante` is cleared and `entulho_limpo` is not pulsed.

## Timing
- Async reset asserted: state = SRST with its 2-cycle count restarted. `robo_rst_n`=0, `step_mode`=0, `robo_en`=0, `removendo`=0, `entulho_restante`=0, `entulho_limpo`=0, `halted`=0. Divider and debouncers are cleared.
- Button latency: a press held stable produces its internal pulse exactly 2+DEB_CYCLES cycles after the first rising clock edge that samples it high. A release must also be stable for DEB_CYCLES before the next press is accepted.
- `robo_en` and `entulho_limpo` are registered and asserted in the cycle after `tick`. At most one `robo_en` per TICK_DIV cycles.
- The transition into HALT is registered; `robo_en` is never high in the cycle `halted` first rises.

## Structure
- `robo_pkg`: state enum (SRST, RUN, REMOVE, HALT), debris-class constants (NONE=0, LEVE=1, MEDIO=2, PESADO=3), removal multiplier 3.
- Sub-module `btn_debounce`: synchronizer, stability counter and edge detector, parameterized by DEB_CYCLES. Instantiated three times.
- The FSM, divider and removal counter live in `robo_exec_ctrl`.

## Test plan
- Reset release, TICK_DIV=4: `robo_rst_n` stays 0 for 2 cycles, then `robo_en` pulses every 4 cycles; `step_mode`=0.
- `btn_mode` held 10 cycles, then `btn_step` pressed three times with clean releases: `step_mode`=1, exactly 3 `robo_en` pulses, none in between.
- Tick with `recolher_entulho`=1 and `entulho_tipo`=2: `removendo`=1 and `entulho_restante`=6. After 6 further ticks, `entulho_limpo` pulses once and `robo_en` resumes on the 7th tick.
- `anomalia`=1 mid-REMOVE with `entulho_restante`=4: `halted`=1, `entulho_restante`=0, and no `robo_en` or `entulho_limpo` for 50 cycles. Then `btn_reset` gives SRST (2 cycles) followed by RUN.
- `btn_step` glitch of 2 cycles with DEB_CYCLES=4: no pulse accepted. `p_mode` and `p_step` in the same cycle: mode toggles, no `robo_en`.
- Async `reset` asserted mid-cycle during RUN: all outputs take their reset values immediately, without waiting for a clock edge.
